// File: rtl/alu16_pkg.sv
// alu16_pkg: shared definitions for the sequential 16-bit ALU.
//   op_e     - operation encoding on the op port
//   state_e  - sequencer states
//   FLAG_*   - bit positions in the 8-bit flag register (f_in / f_out)
//   helpers  - decode of subtract-type ops and ops that consume carry-in
package alu16_pkg;

    typedef enum logic [1:0] {
        OP_ADD16 = 2'b00,
        OP_ADC16 = 2'b01,
        OP_SBC16 = 2'b10,
        OP_CP16  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_P = 2;
    localparam int FLAG_X = 3;
    localparam int FLAG_H = 4;
    localparam int FLAG_Y = 5;
    localparam int FLAG_Z = 6;
    localparam int FLAG_S = 7;

    function automatic logic op_is_sub(op_e i_op);
        return (i_op == OP_SBC16) || (i_op == OP_CP16);
    endfunction

    function automatic logic op_uses_carry(op_e i_op);
        return (i_op == OP_ADC16) || (i_op == OP_SBC16);
    endfunction

endpackage

// File: rtl/alu16_bytestep.sv
// alu16_bytestep: combinational 8-bit add/subtract slice.
//   i_a, i_b  - byte operands
//   i_sub     - 1: compute a - b - borrow, 0: a + b + carry
//   i_cin     - carry-in (add) or borrow-in (sub), flag sense
//   o_sum     - 8-bit result
//   o_cout    - carry-out (add) or borrow-out (sub) of bit 7, flag sense
//   o_hc      - carry/borrow out of bit 3, flag sense
//   o_c7      - raw adder carry into bit 7 (for signed overflow)
module alu16_bytestep (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_sub,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout,
    output logic       o_hc,
    output logic       o_c7
);

    logic [7:0] w_b;
    logic       w_cin;
    logic [4:0] w_lo;
    logic [3:0] w_mid;
    logic [1:0] w_top;

    // Subtraction is a + ~b + ~borrow; raw carries are inverted back to borrows.
    assign w_b   = i_sub ? ~i_b : i_b;
    assign w_cin = i_cin ^ i_sub;

    assign w_lo  = {1'b0, i_a[3:0]} + {1'b0, w_b[3:0]} + {4'b0000, w_cin};
    assign w_mid = {1'b0, i_a[6:4]} + {1'b0, w_b[6:4]} + {3'b000, w_lo[4]};
    assign w_top = {1'b0, i_a[7]}   + {1'b0, w_b[7]}   + {1'b0, w_mid[3]};

    assign o_sum  = {w_top[0], w_mid[2:0], w_lo[3:0]};
    assign o_cout = w_top[1] ^ i_sub;
    assign o_hc   = w_lo[4] ^ i_sub;
    assign o_c7   = w_mid[3];

endmodule

// File: rtl/alu16_seq.sv
// alu16_seq: 16-bit ADD/ADC/SBC/CP computed one byte per cycle.
//   clk, reset  - clock, asynchronous active-high reset
//   start       - begin an operation (accepted in IDLE or DONE only)
//   op          - 00 ADD16, 01 ADC16, 10 SBC16, 11 CP16
//   opa, opb    - operands, latched when start is accepted
//   f_in        - flag register in (C0 N1 P2 X3 H4 Y5 Z6 S7)
//   busy        - high in LO and HI
//   done        - one-cycle pulse when result/f_out are valid
//   result      - registered 16-bit result (opa for CP16)
//   f_out       - registered flags
//
// state   | meaning
// IDLE    | waiting for start
// LO      | low byte computed and registered
// HI      | high byte computed, result and flags registered
// DONE    | done pulse; a new start may be accepted here
module alu16_seq
    import alu16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    input  logic [7:0]  f_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [7:0]  f_out
);

    state_e      r_state, w_next;
    op_e         r_op;
    logic [15:0] r_a, r_b;
    logic        r_fin_c, r_fin_s, r_fin_z, r_fin_p;
    logic [7:0]  r_lo_sum;
    logic        r_lo_c, r_lo_z;
    logic [15:0] r_result;
    logic [7:0]  r_f_out;

    logic        w_accept, w_sub;
    logic [7:0]  w_step_a, w_step_b, w_sum;
    logic        w_step_cin, w_cout, w_hc, w_c7;
    logic [15:0] w_res16;
    logic [7:0]  w_flags;
    logic        w_unused_fin;

    // Only C, S, Z, P of the incoming flags ever influence the output.
    assign w_unused_fin = ^{f_in[5:3], f_in[1]};

    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_sub    = op_is_sub(r_op);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_LO;
            ST_LO: begin
                busy   = 1'b1;
                w_next = ST_HI;
            end
            ST_HI: begin
                busy   = 1'b1;
                w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = start ? ST_LO : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // One byte slice is shared: low bytes in LO, high bytes in HI.
    always_comb begin
        w_step_a   = r_a[7:0];
        w_step_b   = r_b[7:0];
        w_step_cin = op_uses_carry(r_op) & r_fin_c;
        if (r_state == ST_HI) begin
            w_step_a   = r_a[15:8];
            w_step_b   = r_b[15:8];
            w_step_cin = r_lo_c;
        end
    end

    alu16_bytestep u_step (
        .i_a    (w_step_a),
        .i_b    (w_step_b),
        .i_sub  (w_sub),
        .i_cin  (w_step_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_hc   (w_hc),
        .o_c7   (w_c7)
    );

    // Flags always describe the arithmetic result, also for CP16.
    assign w_res16 = {w_sum, r_lo_sum};

    always_comb begin
        w_flags         = 8'h00;
        w_flags[FLAG_C] = w_cout;
        w_flags[FLAG_N] = w_sub;
        w_flags[FLAG_H] = w_hc;
        w_flags[FLAG_X] = w_res16[11];
        w_flags[FLAG_Y] = w_res16[13];
        if (r_op == OP_ADD16) begin
            w_flags[FLAG_S] = r_fin_s;
            w_flags[FLAG_Z] = r_fin_z;
            w_flags[FLAG_P] = r_fin_p;
        end else begin
            w_flags[FLAG_S] = w_res16[15];
            w_flags[FLAG_Z] = r_lo_z && (w_sum == 8'h00);
            // Signed overflow from raw carries: into bit 15 vs out of bit 15.
            w_flags[FLAG_P] = w_c7 ^ (w_cout ^ w_sub);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= OP_ADD16;
            r_a      <= '0;
            r_b      <= '0;
            r_fin_c  <= 1'b0;
            r_fin_s  <= 1'b0;
            r_fin_z  <= 1'b0;
            r_fin_p  <= 1'b0;
            r_lo_sum <= '0;
            r_lo_c   <= 1'b0;
            r_lo_z   <= 1'b0;
            r_result <= '0;
            r_f_out  <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= op_e'(op);
                r_a     <= opa;
                r_b     <= opb;
                r_fin_c <= f_in[FLAG_C];
                r_fin_s <= f_in[FLAG_S];
                r_fin_z <= f_in[FLAG_Z];
                r_fin_p <= f_in[FLAG_P];
            end
            if (r_state == ST_LO) begin
                r_lo_sum <= w_sum;
                r_lo_c   <= w_cout;
                r_lo_z   <= (w_sum == 8'h00);
            end
            if (r_state == ST_HI) begin
                r_result <= (r_op == OP_CP16) ? r_a : w_res16;
                r_f_out  <= w_flags;
            end
        end
    end

    assign result = r_result;
    assign f_out  = r_f_out;

endmodule

// File: tb/tb_alu16_seq.sv
module tb_alu16_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] opa = 16'h0000;
    logic [15:0] opb = 16'h0000;
    logic [7:0]  f_in = 8'h00;
    logic        busy, done;
    logic [15:0] result;
    logic [7:0]  f_out;

    int total = 0;
    int bad = 0;
    logic [15:0] obs_res;
    logic [7:0]  obs_f;

    always #5 clk = ~clk;

    alu16_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .opa    (opa),
        .opb    (opb),
        .f_in   (f_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .f_out  (f_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on whole 16-bit values.
    function automatic void model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                                  input logic [7:0] fi, output logic [15:0] r, output logic [7:0] f);
        int cin, full, half, sres;
        logic sub, c, h, ov;
        logic [15:0] d;
        sub = (o == 2'b10) || (o == 2'b11);
        cin = ((o == 2'b01) || (o == 2'b10)) ? int'(fi[0]) : 0;
        if (!sub) begin
            full = int'(a) + int'(b) + cin;
            half = int'(a[11:0]) + int'(b[11:0]) + cin;
            sres = int'($signed(a)) + int'($signed(b)) + cin;
            c = full > 65535;
            h = half > 4095;
        end else begin
            full = int'(a) - int'(b) - cin;
            half = int'(a[11:0]) - int'(b[11:0]) - cin;
            sres = int'($signed(a)) - int'($signed(b)) - cin;
            c = full < 0;
            h = half < 0;
        end
        ov = (sres > 32767) || (sres < -32768);
        d = 16'(full);
        f = 8'h00;
        f[0] = c;
        f[1] = sub;
        f[3] = d[11];
        f[4] = h;
        f[5] = d[13];
        if (o == 2'b00) begin
            f[7] = fi[7];
            f[6] = fi[6];
            f[2] = fi[2];
        end else begin
            f[7] = d[15];
            f[6] = (d == 16'h0000);
            f[2] = ov;
        end
        r = (o == 2'b11) ? a : d;
    endfunction

    // Start on one edge, scramble inputs afterwards, check timing and results.
    task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] fi, input string tag);
        logic [15:0] er;
        logic [7:0]  ef;
        model(o, a, b, fi, er, ef);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b; f_in = fi;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom_range(3, 0)); opa = 16'($urandom); opb = 16'($urandom); f_in = 8'($urandom);
        chk({tag, " busy@1"}, 32'(busy), 32'd1);
        chk({tag, " done@1"}, 32'(done), 32'd0);
        @(negedge clk);
        chk({tag, " done@2"}, 32'(done), 32'd0);
        @(negedge clk);
        chk({tag, " done@3"}, 32'(done), 32'd1);
        chk({tag, " busy@3"}, 32'(busy), 32'd0);
        chk({tag, " result"}, 32'(result), 32'(er));
        chk({tag, " f_out"}, 32'(f_out), 32'(ef));
        obs_res = result;
        obs_f   = f_out;
        @(negedge clk);
        chk({tag, " done@4"}, 32'(done), 32'd0);
        chk({tag, " hold"}, 32'(result), 32'(er));
    endtask

    initial begin
        logic [15:0] er, er2;
        logic [7:0]  ef, ef2;

        @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst result", 32'(result), 32'd0);
        chk("rst f_out", 32'(f_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_op(2'b00, 16'h0FFF, 16'h0001, 8'hFF, "add16");
        chk("add16 res const", 32'(obs_res), 32'h1000);
        chk("add16 f const", 32'(obs_f), 32'hD4);
        do_op(2'b01, 16'h7FFF, 16'h0000, 8'h01, "adc16");
        chk("adc16 res const", 32'(obs_res), 32'h8000);
        chk("adc16 f const", 32'(obs_f), 32'h94);
        do_op(2'b10, 16'h0000, 16'h0001, 8'h00, "sbc16a");
        chk("sbc16a res const", 32'(obs_res), 32'hFFFF);
        chk("sbc16a f const", 32'(obs_f), 32'hBB);
        do_op(2'b10, 16'h1234, 16'h1234, 8'h00, "sbc16b");
        chk("sbc16b res const", 32'(obs_res), 32'h0000);
        chk("sbc16b f const", 32'(obs_f), 32'h42);
        do_op(2'b10, 16'h1300, 16'h1200, 8'h00, "sbc16c");
        chk("sbc16c Z", 32'(obs_f[6]), 32'd0);
        do_op(2'b11, 16'h1234, 16'h5678, 8'hFF, "cp16");
        chk("cp16 res const", 32'(obs_res), 32'h1234);

        for (int i = 0; i < 40; i++) begin
            do_op(2'($urandom_range(3, 0)), 16'($urandom), 16'($urandom), 8'($urandom), "rand");
        end

        // start held through LO/HI is ignored and not queued
        model(2'b01, 16'hA5A5, 16'h1111, 8'h01, er, ef);
        @(negedge clk);
        start = 1'b1; op = 2'b01; opa = 16'hA5A5; opb = 16'h1111; f_in = 8'h01;
        @(negedge clk);
        opa = 16'h0F0F; opb = 16'h3333; op = 2'b10;
        @(negedge clk);
        opa = 16'h7777;
        @(negedge clk);
        start = 1'b0;
        chk("hold done", 32'(done), 32'd1);
        chk("hold result", 32'(result), 32'(er));
        chk("hold f_out", 32'(f_out), 32'(ef));
        @(negedge clk);
        chk("hold noqueue busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("hold noqueue busy2", 32'(busy), 32'd0);
        chk("hold noqueue done", 32'(done), 32'd0);

        // start in the DONE cycle is accepted
        model(2'b00, 16'h4000, 16'h4000, 8'h00, er, ef);
        model(2'b10, 16'h8000, 16'h0001, 8'h01, er2, ef2);
        start = 1'b1; op = 2'b00; opa = 16'h4000; opb = 16'h4000; f_in = 8'h00;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b done1", 32'(done), 32'd1);
        chk("b2b res1", 32'(result), 32'(er));
        start = 1'b1; op = 2'b10; opa = 16'h8000; opb = 16'h0001; f_in = 8'h01;
        @(negedge clk);
        start = 1'b0;
        chk("b2b busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("b2b done@2", 32'(done), 32'd0);
        @(negedge clk);
        chk("b2b done2", 32'(done), 32'd1);
        chk("b2b res2", 32'(result), 32'(er2));
        chk("b2b f2", 32'(f_out), 32'(ef2));

        // reset while in HI
        do_op(2'b00, 16'h0FFF, 16'h0001, 8'hFF, "pre-rst");
        @(negedge clk);
        start = 1'b1; op = 2'b00; opa = 16'h1111; opb = 16'h2222; f_in = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre-rst busy HI", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst done", 32'(done), 32'd0);
        chk("arst result", 32'(result), 32'd0);
        chk("arst f_out", 32'(f_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post-rst done", 32'(done), 32'd0);
            chk("post-rst busy", 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
